// File: rtl/sdram_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sdram_arb_pkg
// Shared op encoding, default credit limits and width helper for the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    localparam int C_DEF_WR_MAX = 64;
    localparam int C_DEF_RD_MAX = 16;
    localparam int C_DEF_QUIET  = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_tag_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sdram_tag_fifo
// Synchronous FIFO holding the requester id of every outstanding read.
// Rev    : 1.0 - initial release
// ============================================================================
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int P_WIDTH = 2,
    parameter int P_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [P_WIDTH-1:0] i_push_data,
    input  logic               i_pop,
    output logic [P_WIDTH-1:0] o_pop_data,
    output logic               o_empty,
    output logic               o_full
);

    localparam int C_PTR_W = clog2(P_DEPTH);

    logic [P_WIDTH-1:0] r_mem_q [P_DEPTH];
    logic [C_PTR_W:0]   r_wptr_q;
    logic [C_PTR_W:0]   w_wptr_d;
    logic [C_PTR_W:0]   r_rptr_q;
    logic [C_PTR_W:0]   w_rptr_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty    = (r_wptr_q == r_rptr_q);
    assign o_full     = (r_wptr_q[C_PTR_W] != r_rptr_q[C_PTR_W]) &&
                        (r_wptr_q[C_PTR_W-1:0] == r_rptr_q[C_PTR_W-1:0]);
    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;
    assign o_pop_data = r_mem_q[r_rptr_q[C_PTR_W-1:0]];

    always_comb begin
        w_wptr_d = r_wptr_q + (C_PTR_W+1)'(w_push_ok);
        w_rptr_d = r_rptr_q + (C_PTR_W+1)'(w_pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_q[r_wptr_q[C_PTR_W-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sdram_port_arb
// Round-robin, credit-throttled scheduler sharing the sdram_ctrl ports.
// Rev    : 1.0 - initial release
// ============================================================================
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int P_NREQ      = 4,
    parameter int P_DATA_NBIT = 16,
    parameter int P_ADDR_NBIT = 16,
    parameter int P_WR_MAX    = C_DEF_WR_MAX,
    parameter int P_RD_MAX    = C_DEF_RD_MAX,
    parameter int P_QUIET     = C_DEF_QUIET
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [P_NREQ-1:0]             req_valid,
    input  logic [P_NREQ-1:0]             req_we,
    input  logic [P_NREQ*P_ADDR_NBIT-1:0] req_addr,
    input  logic [P_NREQ*P_DATA_NBIT-1:0] req_wdata,
    output logic [P_NREQ-1:0]             req_ready,
    output logic [P_DATA_NBIT-1:0]        rsp_data,
    output logic [P_NREQ-1:0]             rsp_valid,
    output logic                          wren,
    output logic [P_ADDR_NBIT-1:0]        waddr,
    output logic [P_DATA_NBIT-1:0]        wdata,
    input  logic                          wstatus,
    output logic                          rd,
    output logic [P_ADDR_NBIT-1:0]        raddr,
    input  logic [P_DATA_NBIT-1:0]        rdata,
    input  logic                          rdv,
    output logic                          busy,
    output logic                          err_orphan
);

    localparam int C_TAG_W = clog2(P_NREQ);
    localparam int C_SUM_W = C_TAG_W + 1;
    localparam int C_WR_W  = clog2(P_WR_MAX + 1);
    localparam int C_RD_W  = clog2(P_RD_MAX + 1);
    localparam int C_Q_W   = clog2(P_QUIET + 1);

    localparam logic [C_WR_W-1:0]  C_WR_MAX = C_WR_W'(P_WR_MAX);
    localparam logic [C_RD_W-1:0]  C_RD_MAX = C_RD_W'(P_RD_MAX);
    localparam logic [C_Q_W-1:0]   C_QUIET  = C_Q_W'(P_QUIET);
    localparam logic [C_TAG_W-1:0] C_LAST   = C_TAG_W'(P_NREQ - 1);

    logic [P_ADDR_NBIT-1:0] w_addr_a  [P_NREQ];
    logic [P_DATA_NBIT-1:0] w_wdata_a [P_NREQ];
    logic [P_NREQ-1:0]      w_elig;
    logic [P_NREQ-1:0]      w_grant;
    logic                   w_gnt_any;
    logic [C_TAG_W-1:0]     w_gnt_id;
    logic [C_SUM_W-1:0]     w_sum;
    logic [C_TAG_W-1:0]     w_cand;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_pop_ok;
    logic [C_TAG_W-1:0]     w_tag;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;

    logic [C_WR_W-1:0]      r_wr_pend_q,  w_wr_pend_d;
    logic [C_RD_W-1:0]      r_rd_out_q,   w_rd_out_d;
    logic [C_Q_W-1:0]       r_quiet_q,    w_quiet_d;
    logic [C_TAG_W-1:0]     r_ptr_q,      w_ptr_d;
    logic                   r_wren_q,     w_wren_d;
    logic                   r_rd_q,       w_rd_d;
    logic [P_ADDR_NBIT-1:0] r_waddr_q,    w_waddr_d;
    logic [P_DATA_NBIT-1:0] r_wdata_q,    w_wdata_d;
    logic [P_ADDR_NBIT-1:0] r_raddr_q,    w_raddr_d;
    logic [P_DATA_NBIT-1:0] r_rsp_data_q, w_rsp_data_d;
    logic [P_NREQ-1:0]      r_rsp_vld_q,  w_rsp_vld_d;
    logic                   r_err_q,      w_err_d;

    // Reads wait for the write buffer to drain so they never overtake a write.
    assign w_wr_ok = (r_wr_pend_q < C_WR_MAX);
    assign w_rd_ok = (r_rd_out_q < C_RD_MAX) && (r_wr_pend_q == '0) && !w_fifo_full;

    generate
        for (genvar gi = 0; gi < P_NREQ; gi++) begin : g_req
            assign w_addr_a[gi]  = req_addr[gi*P_ADDR_NBIT +: P_ADDR_NBIT];
            assign w_wdata_a[gi] = req_wdata[gi*P_DATA_NBIT +: P_DATA_NBIT];
            assign w_elig[gi]    = req_valid[gi] &
                                   ((req_we[gi] == OP_WR) ? w_wr_ok : w_rd_ok);
        end
    endgenerate

    always_comb begin
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < P_NREQ; k++) begin
            w_sum = {1'b0, r_ptr_q} + C_SUM_W'(k);
            if (w_sum >= C_SUM_W'(P_NREQ)) begin
                w_sum = w_sum - C_SUM_W'(P_NREQ);
            end
            w_cand = w_sum[C_TAG_W-1:0];
            if (!rst && !w_gnt_any && w_elig[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_cand;
            end
        end
        if (w_gnt_any) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign w_wr_acc  = w_gnt_any & (req_we[w_gnt_id] == OP_WR);
    assign w_rd_acc  = w_gnt_any & (req_we[w_gnt_id] == OP_RD);
    assign w_pop_ok  = rdv & ~w_fifo_empty;

    sdram_tag_fifo #(
        .P_WIDTH (C_TAG_W),
        .P_DEPTH (P_RD_MAX)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rd_acc),
        .i_push_data (w_gnt_id),
        .i_pop       (rdv),
        .o_pop_data  (w_tag),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    always_comb begin
        w_wren_d     = w_wr_acc;
        w_rd_d       = w_rd_acc;
        w_waddr_d    = w_wr_acc ? w_addr_a[w_gnt_id]  : r_waddr_q;
        w_wdata_d    = w_wr_acc ? w_wdata_a[w_gnt_id] : r_wdata_q;
        w_raddr_d    = w_rd_acc ? w_addr_a[w_gnt_id]  : r_raddr_q;
        w_ptr_d      = r_ptr_q;
        if (w_gnt_any) begin
            w_ptr_d = (w_gnt_id == C_LAST) ? '0 : w_gnt_id + 1'b1;
        end

        // The buffer exposes no full flag, so credit is reclaimed only once
        // it reports empty after a quiet period with no new writes.
        w_wr_pend_d = r_wr_pend_q;
        if (w_wr_acc) begin
            if (r_wr_pend_q != C_WR_MAX) begin
                w_wr_pend_d = r_wr_pend_q + 1'b1;
            end
        end else if (wstatus && (r_quiet_q == C_QUIET)) begin
            w_wr_pend_d = '0;
        end

        w_quiet_d = r_quiet_q;
        if (w_wr_acc) begin
            w_quiet_d = '0;
        end else if (r_quiet_q != C_QUIET) begin
            w_quiet_d = r_quiet_q + 1'b1;
        end

        w_rd_out_d = r_rd_out_q;
        if (w_rd_acc && !w_pop_ok) begin
            w_rd_out_d = r_rd_out_q + 1'b1;
        end else if (!w_rd_acc && w_pop_ok) begin
            w_rd_out_d = r_rd_out_q - 1'b1;
        end

        w_rsp_vld_d  = '0;
        w_rsp_data_d = r_rsp_data_q;
        if (w_pop_ok) begin
            w_rsp_vld_d[w_tag] = 1'b1;
            w_rsp_data_d       = rdata;
        end
        w_err_d = r_err_q | (rdv & w_fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_pend_q  <= '0;
            r_rd_out_q   <= '0;
            r_quiet_q    <= '0;
            r_ptr_q      <= '0;
            r_wren_q     <= 1'b0;
            r_rd_q       <= 1'b0;
            r_waddr_q    <= '0;
            r_wdata_q    <= '0;
            r_raddr_q    <= '0;
            r_rsp_data_q <= '0;
            r_rsp_vld_q  <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_wr_pend_q  <= w_wr_pend_d;
            r_rd_out_q   <= w_rd_out_d;
            r_quiet_q    <= w_quiet_d;
            r_ptr_q      <= w_ptr_d;
            r_wren_q     <= w_wren_d;
            r_rd_q       <= w_rd_d;
            r_waddr_q    <= w_waddr_d;
            r_wdata_q    <= w_wdata_d;
            r_raddr_q    <= w_raddr_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_rsp_vld_q  <= w_rsp_vld_d;
            r_err_q      <= w_err_d;
        end
    end

    assign wren       = r_wren_q;
    assign rd         = r_rd_q;
    assign waddr      = r_waddr_q;
    assign wdata      = r_wdata_q;
    assign raddr      = r_raddr_q;
    assign rsp_data   = r_rsp_data_q;
    assign rsp_valid  = r_rsp_vld_q;
    assign err_orphan = r_err_q;
    assign busy       = (r_wr_pend_q != '0) || (r_rd_out_q != '0);

endmodule
`default_nettype wire
